// File: rtl/notch_coeff_ctrl.sv
// Coefficient controller for the half-band notch filter.
// Holds a host-writable shadow bank of 14 taps and sequences a glitch-free
// copy into the active bank, blanking the filter output while coefficients settle.
module notch_coeff_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 24
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         wr_i,
    input  logic [3:0]   addr_i,
    input  logic [17:0]  wdata_i,
    output logic [17:0]  rdata_o,
    input  logic         update_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [251:0] coeff_o,
    output logic         coeff_ce_o,
    output logic         blank_o
);

    localparam int unsigned COEFF_W  = 18;
    localparam int unsigned NUM_TAPS = 14;
    localparam int unsigned CHAIN_N  = 7;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned IDX_W    = 4;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    // Power-on bank: positive chain taps 0-6 followed by negative chain taps 0-6
    localparam logic [COEFF_W-1:0] RESET_BANK [NUM_TAPS] = '{
        18'(151),  18'(340),  18'(551),  18'(761),  18'(947),  18'(1086),  18'(1160),
        18'(-70),  18'(-241), 18'(-444), 18'(-657), 18'(-858), 18'(-1023), 18'(-1133)
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               load_c;
    logic               done_d;

    logic [COEFF_W-1:0] shadow_q [NUM_TAPS];
    logic [COEFF_W-1:0] shadow_d [NUM_TAPS];
    logic [COEFF_W-1:0] rdata_d;
    logic               hit_c;
    logic [IDX_W-1:0]   idx_c;

    // Address decode: tap 7 of either chain is unmapped
    always_comb begin
        hit_c = (addr_i[2:0] != 3'd7);
        idx_c = addr_i[3] ? (IDX_W'(addr_i[2:0]) + IDX_W'(CHAIN_N)) : IDX_W'(addr_i[2:0]);
    end

    // Shadow bank with this cycle's write applied (also the forwarded copy source)
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            shadow_d[k] = (wr_i && hit_c && (idx_c == IDX_W'(k))) ? wdata_i : shadow_q[k];
        end
    end

    // Readback mux on the pre-write shadow contents
    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (hit_c && (idx_c == IDX_W'(k))) begin
                rdata_d = shadow_q[k];
            end
        end
    end

    // Next-state logic: one LOAD cycle, then SETTLE_CYCLES of settling
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        load_c  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (update_i) begin
                    state_d = LOAD;
                    load_c  = 1'b1;
                    pend_d  = 1'b0;
                end
            end
            LOAD: begin
                state_d = SETTLE;
                if (update_i) begin
                    pend_d = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                    if (pend_q || update_i) begin
                        // A queued request is consumed; a new one in this cycle re-queues
                        state_d = LOAD;
                        load_c  = 1'b1;
                        pend_d  = pend_q && update_i;
                    end else begin
                        state_d = IDLE;
                        pend_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (update_i) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 1'b0;
            end
        endcase
        if (load_c) begin
            cnt_d = CNT_LOAD;
        end
    end

    // FSM state, settle counter and request queue
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= SETTLE;
            cnt_q   <= CNT_LOAD;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Shadow bank storage and registered readback
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow_q[k] <= RESET_BANK[k];
            end
            rdata_o <= '0;
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
            rdata_o <= rdata_d;
        end
    end

    // Active bank changes only on the edge entering LOAD
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coeff_o[COEFF_W*k +: COEFF_W] <= RESET_BANK[k];
            end
        end else if (load_c) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coeff_o[COEFF_W*k +: COEFF_W] <= shadow_d[k];
            end
        end
    end

    // Registered status outputs aligned with the state they describe
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            blank_o    <= 1'b1;
            busy_o     <= 1'b1;
            coeff_ce_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            blank_o    <= (state_d != IDLE);
            busy_o     <= (state_d != IDLE);
            coeff_ce_o <= load_c;
            done_o     <= done_d;
        end
    end

endmodule

// File: tb/tb_notch_coeff_ctrl.sv
// Self-checking bench for notch_coeff_ctrl: directed scenarios plus random traffic
// compared every cycle against a sequence-length reference model.
module tb_notch_coeff_ctrl;

    localparam int unsigned SC = 24;
    localparam int RST_VALS [14] = '{151, 340, 551, 761, 947, 1086, 1160,
                                     -70, -241, -444, -657, -858, -1023, -1133};

    logic         clk = 1'b0;
    logic         rstn, wr, upd;
    logic [3:0]   addr;
    logic [17:0]  wdata;
    logic [17:0]  rdata;
    logic         busy, done, ce, blank;
    logic [251:0] coeff;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [17:0] m_shadow [14];
    logic [17:0] m_active [14];
    int          m_remain;
    bit          m_queued;
    logic [17:0] e_rdata;
    bit          e_ce, e_blank, e_busy, e_done;

    always #5 clk = ~clk;

    notch_coeff_ctrl #(.SETTLE_CYCLES(SC)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .wr_i       (wr),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .update_i   (upd),
        .busy_o     (busy),
        .done_o     (done),
        .coeff_o    (coeff),
        .coeff_ce_o (ce),
        .blank_o    (blank)
    );

    task automatic check(input string tag, input logic [251:0] got, input logic [251:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [251:0] reset_bank();
        logic [251:0] r;
        for (int k = 0; k < 14; k++) r[18*k +: 18] = 18'(RST_VALS[k]);
        return r;
    endfunction

    function automatic logic [251:0] model_bank();
        logic [251:0] r;
        for (int k = 0; k < 14; k++) r[18*k +: 18] = m_active[k];
        return r;
    endfunction

    // Model: a sequence occupies SC+1 cycles; m_remain counts cycles left in it
    task automatic model_step();
        int  tap, idx;
        bit  fin, start, valid;
        if (!rstn) begin
            for (int k = 0; k < 14; k++) begin
                m_shadow[k] = 18'(RST_VALS[k]);
                m_active[k] = 18'(RST_VALS[k]);
            end
            m_remain = SC;
            m_queued = 0;
            e_rdata  = '0;
            e_ce     = 0;
            e_done   = 0;
        end else begin
            tap   = int'(addr) % 8;
            idx   = (int'(addr) / 8) * 7 + tap;
            valid = (tap != 7);
            e_rdata = valid ? m_shadow[idx] : 18'd0;
            fin   = (m_remain == 1);
            start = (m_remain == 0 && upd) || (fin && (m_queued || upd));
            if (m_remain == 0)  m_queued = 0;
            else if (fin)       m_queued = m_queued && upd;
            else                m_queued = m_queued || upd;
            if (wr && valid) m_shadow[idx] = wdata;
            e_done = fin;
            e_ce   = start;
            if (start) begin
                for (int k = 0; k < 14; k++) m_active[k] = m_shadow[k];
                m_remain = SC + 1;
            end else if (m_remain > 0) begin
                m_remain--;
            end
        end
        e_blank = (m_remain > 0);
        e_busy  = (m_remain > 0);
    endtask

    // Drive one cycle, advance the model at the edge, compare at the falling edge
    task automatic cycle(input bit r, input bit w, input logic [3:0] a,
                         input logic [17:0] d, input bit u);
        rstn = r; wr = w; addr = a; wdata = d; upd = u;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("rdata", rdata, e_rdata);
        check("coeff", coeff, model_bank());
        check("coeff_ce", ce, e_ce);
        check("blank", blank, e_blank);
        check("busy", busy, e_busy);
        check("done", done, e_done);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && e_busy; i++) cycle(1, 0, 0, 0, 0);
    endtask

    // Count blank cycles (including the current one) until done is seen
    task automatic blank_run(output int nb, output bit seen);
        nb   = blank ? 1 : 0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (done) seen = 1;
            else if (blank) nb++;
        end
    endtask

    initial begin
        int nb, nce, done_at, nload, coin, gap;
        bit seen, fin_seen;
        rstn = 0; wr = 0; upd = 0; addr = '0; wdata = '0;

        // Reset
        repeat (3) cycle(0, 0, 0, 0, 0);
        check("rst_pos0", coeff[17:0], 18'd151);
        check("rst_neg0", coeff[18*7 +: 18], 18'h3FFBA);
        check("rst_blank", blank, 1'b1);
        blank_run(nb, seen);
        check("rst_done_seen", seen, 1'b1);
        check("rst_blank_len", nb, SC);

        // Write / readback / unmapped
        cycle(1, 1, 4'd3, 18'd500, 0);
        cycle(1, 0, 4'd3, 18'd0, 0);
        check("rd_addr3", rdata, 18'd500);
        cycle(1, 1, 4'd7, 18'h12345, 0);
        cycle(1, 0, 4'd7, 18'd0, 0);
        check("rd_addr7", rdata, 18'd0);
        check("coeff_unchanged", coeff, reset_bank());
        cycle(1, 1, 4'd14, 18'h3FFFF, 0);
        cycle(1, 0, 4'd14, 18'd0, 0);
        check("rd_addr14", rdata, 18'h3FFFF);

        // Update sequence
        cycle(1, 1, 4'd0, 18'd1000, 0);
        cycle(1, 0, 4'd0, 18'd0, 1);
        check("upd_load_val", coeff[17:0], 18'd1000);
        check("upd_ce", ce, 1'b1);
        nce = ce ? 1 : 0; nb = blank ? 1 : 0; done_at = 0;
        for (int i = 1; i < 40 && done_at == 0; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (ce) nce++;
            if (done) done_at = i + 1;
            else if (blank) nb++;
        end
        check("upd_ce_count", nce, 1);
        check("upd_blank_len", nb, SC + 1);
        check("upd_done_at", done_at, SC + 2);

        // Forwarding of a write coincident with the accepting edge
        cycle(1, 1, 4'd8, 18'h3FFFB, 1);
        check("fwd_neg0", coeff[18*7 +: 18], 18'h3FFFB);
        drain();

        // Pending merge
        cycle(1, 0, 0, 0, 1);
        nload = ce ? 1 : 0; coin = 0; gap = 0; fin_seen = 0;
        for (int i = 1; i < 80 && !fin_seen; i++) begin
            cycle(1, 0, 0, 0, (i == 3 || i == 8 || i == 15));
            if (ce) nload++;
            if (ce && done) coin++;
            if (done && !ce) fin_seen = 1;
            else if (!blank) gap++;
        end
        check("merge_loads", nload, 2);
        check("merge_coincide", coin, 1);
        check("merge_blank_gap", gap, 0);
        check("merge_finished", fin_seen, 1'b1);

        // Abort mid-SETTLE
        cycle(1, 1, 4'd5, 18'd777, 0);
        cycle(1, 0, 0, 0, 1);
        check("abort_loaded", coeff[18*5 +: 18], 18'd777);
        repeat (10) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check("abort_bank", coeff, reset_bank());
        check("abort_ce", ce, 1'b0);
        blank_run(nb, seen);
        check("abort_blank_len", nb, SC);
        check("abort_done_seen", seen, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) == 0),
                  4'($urandom_range(0, 15)), 18'($urandom),
                  ($urandom_range(0, 9) == 0));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/notch_coeff_ctrl.md
# notch_coeff_ctrl

Coefficient controller for the 4-sample half-band notch filter: holds a host-writable shadow bank of the 14 notch taps (7 positive-chain, 7 negative-chain) and sequences glitch-free transfer into the active bank that drives the filter's DSP B inputs. Around each swap it raises an output blanking flag for a programmable settling time, so downstream logic discards samples computed with mixed old and new coefficients. Sits between the register/control bus and the notch datapath, one instance per notch.

## Interface

- SETTLE_CYCLES, 24: cycles `blank_o` stays high after a coefficient load; legal range 1–255.

- clk_i  in  1  single clock (filter clock domain)
- rstn_i  in  1  synchronous reset, active-low
- wr_i  in  1  shadow write strobe
- addr_i  in  4  tap address; [3]=0 positive chain, 1 negative chain; [2:0]=tap 0–6; tap 7 unmapped
- wdata_i  in  18  two's-complement coefficient
- rdata_o  out  18  registered shadow readback of addr_i
- update_i  in  1  request shadow→active transfer (single-cycle pulse)
- busy_o  out  1  sequence in progress (state ≠ IDLE)
- done_o  out  1  one-cycle pulse at end of each sequence
- coeff_o  out  252  active bank; coeff_o[18k +: 18], k=0–6 positive taps 0–6, k=7–13 negative taps 0–6
- coeff_ce_o  out  1  load enable to filter coefficient registers
- blank_o  out  1  filter output invalid

## Operation

- Reset bank: positive 151, 340, 551, 761, 947, 1086, 1160. Negative −70, −241, −444, −657, −858, −1023, −1133. Both shadow and active banks load these on reset.
- Shadow writes are accepted in every state. A write to tap 7 (addr 7 or 15) has no effect. The active bank changes only on entry to LOAD.
- Readback: rdata_o <= shadow[addr_i] every cycle, 1-cycle latency. Unmapped addresses read 0. A write and a read of the same address in the same cycle return the old value.
- FSM states: IDLE, LOAD, SETTLE.
  - IDLE → LOAD when update_i=1.
  - LOAD → SETTLE always, after 1 cycle.
  - SETTLE → LOAD when the count expires and pending=1; otherwise SETTLE → IDLE when the count expires.
- Entering LOAD:
  - The active bank copies the shadow bank. A wr_i in the same cycle as the accepting edge is forwarded, so the new value is included.
  - The pending flag clears.
  - The settle counter loads SETTLE_CYCLES−1.
- SETTLE: the counter decrements each cycle and expires in the cycle it reads 0. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- Pending flag:
  - update_i in LOAD or SETTLE sets pending. This is a single-depth queue; extra requests merge.
  - update_i in the cycle a pending request is consumed sets pending again.
- Outputs:
  - coeff_ce_o=1 only during LOAD.
  - blank_o=1 during LOAD and SETTLE.
  - busy_o=1 outside IDLE.
  - done_o pulses in the cycle after the final SETTLE cycle, including when the next state is LOAD.
- Reset values:
  - State SETTLE, counter SETTLE_CYCLES−1, pending 0.
  - blank_o=1, busy_o=1, coeff_ce_o=0, done_o=0, rdata_o=0, coeff_o = reset bank.
  - The first done_o appears SETTLE_CYCLES cycles after rstn_i rises.
- Reset asserted mid-sequence aborts it. The next cycle shows the reset values above; there is no partial-copy state.

## Timing

- update_i high at edge N (FSM in IDLE):
  - Cycle N+1: LOAD. coeff_o holds the new values, coeff_ce_o=1, blank_o=1, busy_o=1.
  - Cycles N+2 … N+1+SETTLE_CYCLES: SETTLE, blank_o=1.
  - Cycle N+2+SETTLE_CYCLES: done_o=1, IDLE, blank_o=0, busy_o=0.
- coeff_o is registered and changes only on the edge entering LOAD. The filter samples it with coeff_ce_o on the next edge.
- Back-to-back sequences: done_o and coeff_ce_o are high in the same cycle, and blank_o never deasserts between them.
- update_i in IDLE has a minimum 1-cycle accept latency. Throughput is one sequence per SETTLE_CYCLES+1 cycles.

## Test plan

- Reset: hold rstn_i low 3 cycles, then release.
  - coeff_o[17:0]=151 and coeff_o[18*7 +: 18]=−70 (0x3FFBA).
  - blank_o=1 for 24 cycles, then done_o pulses and blank_o=0.
- Write/readback and unmapped addresses:
  - Write 500 to addr 3; read it 1 cycle later and get 500.
  - Write 0x12345 to addr 7; readback is 0 and coeff_o is unchanged.
  - Write −1 to addr 14; readback is 0x3FFFF.
- Update sequence: write 1000 to addr 0, then pulse update_i.
  - LOAD occurs 1 cycle later, with coeff_o[17:0]=1000 and coeff_ce_o high for exactly 1 cycle.
  - blank_o is high for 25 cycles total; done_o follows on cycle 26.
- Forwarding: assert wr_i (addr 8, value −5) in the same cycle as update_i. After LOAD, coeff_o[18*7 +: 18]=−5.
- Pending merge:
  - Pulse update_i 3 times during SETTLE. Exactly 2 LOAD cycles occur in total.
  - done_o coincides with the 2nd coeff_ce_o, and blank_o stays continuously high.
- Abort: pull rstn_i low in SETTLE cycle 10 after loading a modified bank.
  - The next cycle shows the reset bank on coeff_o and pending=0.
  - A fresh 24-cycle blank follows release.
